ritc_storage_readout_ctrl: RTL

Parametrised user-clock-domain readout controller for the RITC sample storage memory. It owns the storage control/status registers, the multi-buffer read pointer, and the channel/buffer/word read-address sequencer. With autoclear built in, it frees a buffer automatically after its last word is read. It sits between the user register bus and the sample memory/address generator, and exports the Gray-coded read pointer back to the sysclk write side.

---
 rtl/ritc_storage_pkg.sv | 30 +++
 rtl/ritc_storage_readout_ctrl_gray_ptr_sync.sv | 34 +++
 rtl/ritc_storage_readout_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ritc_storage_pkg.sv
// Shared constants for the RITC storage readout controller: register map,
// CTRL/STATUS bit positions, CONFIG version and readout state encoding.
package ritc_storage_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_ADDR   = 2'd1;
   localparam logic [1:0] REG_CONFIG = 2'd2;
   localparam logic [1:0] REG_FREED  = 2'd3;

   localparam int CTRL_SOFT_TRIG   = 1;
   localparam int CTRL_CLEAR       = 2;
   localparam int CTRL_RESET_REQ   = 3;
   localparam int CTRL_TRIG_EN     = 4;
   localparam int CTRL_EXT_TRIG_EN = 5;
   localparam int CTRL_AUTOCLEAR   = 6;

   localparam int STAT_AVAIL   = 0;
   localparam int STAT_WR_LSB  = 8;
   localparam int STAT_RD_LSB  = 12;
   localparam int STAT_OCC_LSB = 16;

   localparam logic [7:0] CFG_VERSION = 8'h02;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_READY   = 2'd1,
      ST_RELEASE = 2'd2
   } rd_state_e;

endpackage

// File: rtl/ritc_storage_readout_ctrl_gray_ptr_sync.sv
// Two-flop synchroniser for the sysclk Gray write pointer, followed by a
// combinational Gray-to-binary conversion in the user clock domain.
module gray_ptr_sync #(
   parameter int BW = 2
) (
   input  logic          user_clk_i,
   input  logic          reset,
   input  logic [BW-1:0] gray_i,
   output logic [BW-1:0] bin_o
);

   logic [BW-1:0] meta_r;
   logic [BW-1:0] sync_r;

   // synchroniser flops; Gray coding keeps any skew to a single-bit ambiguity
   always_ff @(posedge user_clk_i) begin
      if (reset) begin
         meta_r <= {BW{1'b0}};
         sync_r <= {BW{1'b0}};
      end else begin
         meta_r <= gray_i;
         sync_r <= meta_r;
      end
   end

   // each binary bit is the XOR of all Gray bits at and above it
   always_comb begin
      bin_o = {BW{1'b0}};
      for (int i = 0; i < BW; i++) begin
         bin_o[i] = ^(sync_r >> i);
      end
   end

endmodule

// File: rtl/ritc_storage_readout_ctrl.sv
// RITC storage readout controller: control/status registers, read-buffer pointer
// and chan/word sequencer. Define RITC_READOUT_AUTOCLEAR_EN for last-word autoclear.
module ritc_storage_readout_ctrl
   import ritc_storage_pkg::*;
#(
   parameter  int NCHAN = 6,
   parameter  int NBUF  = 4,
   parameter  int DEPTH = 512,
   localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1,
   localparam int BW    = $clog2(NBUF),
   localparam int DW    = $clog2(DEPTH)
) (
   input  logic             user_clk_i,
   input  logic             reset,
   input  logic             user_sel_i,
   input  logic             user_wr_i,
   input  logic [1:0]       user_addr_i,
   input  logic [31:0]      user_dat_i,
   output logic [31:0]      user_dat_o,
   input  logic             sample_sel_i,
   input  logic             sample_rd_i,
   input  logic [BW-1:0]    wr_buf_gray_i,
   output logic [BW-1:0]    rd_buf_gray_o,
   output logic [CW+BW+DW-1:0] raddr_o,
   output logic             rd_en_o,
   output logic             trig_en_o,
   output logic             ext_trig_en_o,
   output logic             soft_trig_o,
   output logic             reset_req_o,
   output logic             buf_done_o
);

   localparam logic [CW-1:0] CHAN_LAST = CW'(NCHAN - 1);
   localparam logic [DW-1:0] WORD_LAST = {DW{1'b1}};

   logic [BW-1:0] wr_bin_s, occ_s, rd_bin_inc_s;
   logic          avail_s;
   logic [BW-1:0] rd_bin_r, rd_gray_r;
   rd_state_e     state_r, state_nxt_s;
   logic          rd_en_r, buf_done_r, soft_trig_r, reset_req_r;
   logic          trig_en_r, ext_trig_en_r, autoclear_s;
   logic [31:0]   freed_r;
   logic [CW-1:0] chan_r, seq_chan_s, ld_chan_s;
   logic [DW-1:0] word_r, seq_word_s;
   logic          ctrl_wr_s, addr_ld_s, strobe_s, clear_s, rst_req_s;
   logic          last_s, release_s;
   logic [31:0]   status_s;
   logic          unused_s;

   gray_ptr_sync #(.BW(BW)) u_wr_sync (
      .user_clk_i (user_clk_i),
      .reset      (reset),
      .gray_i     (wr_buf_gray_i),
      .bin_o      (wr_bin_s)
   );

   assign occ_s        = wr_bin_s - rd_bin_r;
   assign avail_s      = (occ_s != {BW{1'b0}});
   assign rd_bin_inc_s = rd_bin_r + BW'(1'b1);

   // a register-window write wins over a sample-window write when both are selected
   assign ctrl_wr_s = user_sel_i & user_wr_i & (user_addr_i == REG_CTRL);
   assign addr_ld_s = user_wr_i & (user_sel_i ? (user_addr_i == REG_ADDR) : sample_sel_i);
   assign strobe_s  = sample_sel_i & sample_rd_i & (state_r == ST_READY) & ~addr_ld_s;
   assign clear_s   = ctrl_wr_s & user_dat_i[CTRL_CLEAR];
   assign rst_req_s = ctrl_wr_s & user_dat_i[CTRL_RESET_REQ];
   assign release_s = (state_r == ST_READY) & (clear_s | (autoclear_s & last_s));
   assign unused_s  = ^{user_dat_i[31:CW+DW]};

`ifdef RITC_READOUT_AUTOCLEAR_EN
   logic autoclear_r;

   // autoclear enable, rewritten on every CTRL write
   always_ff @(posedge user_clk_i) begin
      if (reset) begin
         autoclear_r <= 1'b0;
      end else if (ctrl_wr_s) begin
         autoclear_r <= user_dat_i[CTRL_AUTOCLEAR];
      end else begin
         autoclear_r <= autoclear_r;
      end
   end
   assign autoclear_s = autoclear_r;
`else
   assign autoclear_s = 1'b0;
`endif

   // sequencer increment: word first, then channel, flagging the buffer's last word
   always_comb begin
      seq_chan_s = chan_r;
      seq_word_s = word_r;
      last_s     = 1'b0;
      if (strobe_s) begin
         seq_word_s = word_r + DW'(1'b1);
         if (word_r == WORD_LAST) begin
            if (chan_r == CHAN_LAST) begin
               seq_chan_s = {CW{1'b0}};
               last_s     = 1'b1;
            end else begin
               seq_chan_s = chan_r + CW'(1'b1);
            end
         end else begin
            seq_chan_s = chan_r;
         end
      end else begin
         seq_word_s = word_r;
      end
   end

   // loaded channel numbers beyond the last channel clamp to it
   always_comb begin
      ld_chan_s = user_dat_i[DW +: CW];
      if (ld_chan_s > CHAN_LAST) begin
         ld_chan_s = CHAN_LAST;
      end else begin
         ld_chan_s = user_dat_i[DW +: CW];
      end
   end

   // readout state transitions
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_EMPTY:   state_nxt_s = avail_s ? ST_READY : ST_EMPTY;
         ST_READY: begin
            if (release_s) begin
               state_nxt_s = ST_RELEASE;
            end else if (!avail_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_READY;
            end
         end
         ST_RELEASE: state_nxt_s = avail_s ? ST_READY : ST_EMPTY;
         default:    state_nxt_s = ST_EMPTY;
      endcase
   end

   // state, read pointer, release bookkeeping and one-cycle pulses
   always_ff @(posedge user_clk_i) begin
      if (reset) begin
         state_r     <= ST_EMPTY;
         rd_en_r     <= 1'b0;
         rd_bin_r    <= {BW{1'b0}};
         rd_gray_r   <= {BW{1'b0}};
         freed_r     <= 32'd0;
         buf_done_r  <= 1'b0;
         soft_trig_r <= 1'b0;
         reset_req_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         rd_en_r     <= (state_nxt_s == ST_READY);
         buf_done_r  <= release_s;
         soft_trig_r <= ctrl_wr_s & user_dat_i[CTRL_SOFT_TRIG];
         reset_req_r <= rst_req_s;
         if (release_s) begin
            rd_bin_r  <= rd_bin_inc_s;
            rd_gray_r <= rd_bin_inc_s ^ (rd_bin_inc_s >> 1'b1);
            freed_r   <= freed_r + 32'd1;
         end else begin
            rd_bin_r  <= rd_bin_r;
            rd_gray_r <= rd_gray_r;
            freed_r   <= freed_r;
         end
      end
   end

   // sequencer address register
   always_ff @(posedge user_clk_i) begin
      if (reset) begin
         chan_r <= {CW{1'b0}};
         word_r <= {DW{1'b0}};
      end else if (rst_req_s || release_s) begin
         chan_r <= {CW{1'b0}};
         word_r <= {DW{1'b0}};
      end else if (addr_ld_s) begin
         chan_r <= ld_chan_s;
         word_r <= user_dat_i[DW-1:0];
      end else begin
         chan_r <= seq_chan_s;
         word_r <= seq_word_s;
      end
   end

   // trigger enable levels
   always_ff @(posedge user_clk_i) begin
      if (reset) begin
         trig_en_r     <= 1'b0;
         ext_trig_en_r <= 1'b0;
      end else if (ctrl_wr_s) begin
         trig_en_r     <= user_dat_i[CTRL_TRIG_EN];
         ext_trig_en_r <= user_dat_i[CTRL_EXT_TRIG_EN];
      end else begin
         trig_en_r     <= trig_en_r;
         ext_trig_en_r <= ext_trig_en_r;
      end
   end

   // status word assembly
   always_comb begin
      status_s                         = 32'd0;
      status_s[STAT_AVAIL]             = avail_s;
      status_s[CTRL_TRIG_EN]           = trig_en_r;
      status_s[CTRL_EXT_TRIG_EN]       = ext_trig_en_r;
      status_s[CTRL_AUTOCLEAR]         = autoclear_s;
      status_s[STAT_WR_LSB +: 4]       = 4'(wr_bin_s);
      status_s[STAT_RD_LSB +: 4]       = 4'(rd_bin_r);
      status_s[STAT_OCC_LSB +: 4]      = 4'(occ_s);
   end

   // register read mux
   always_comb begin
      case (user_addr_i)
         REG_CTRL:   user_dat_o = status_s;
         REG_ADDR:   user_dat_o = 32'({chan_r, word_r});
         REG_CONFIG: user_dat_o = {8'(NCHAN), 8'(NBUF), 8'(DW), CFG_VERSION};
         REG_FREED:  user_dat_o = freed_r;
         default:    user_dat_o = 32'd0;
      endcase
   end

   assign rd_buf_gray_o = rd_gray_r;
   assign raddr_o       = {chan_r, rd_bin_r, word_r};
   assign rd_en_o       = rd_en_r;
   assign trig_en_o     = trig_en_r;
   assign ext_trig_en_o = ext_trig_en_r;
   assign soft_trig_o   = soft_trig_r;
   assign reset_req_o   = reset_req_r;
   assign buf_done_o    = buf_done_r;

endmodule
